apb2wb: RTL and testbench
=========================

# apb2wb

APB-to-Wishbone bridge: APB completer (slave) that converts each APB transfer into one classic single Wishbone cycle as Wishbone master. It sits behind the APB interconnect so APB-side masters (debug/config units) can reach Wishbone-resident slaves. Each APB transfer is held with PREADY low until the Wishbone slave acks or errs, or, when the timeout feature is built, until the timeout expires.

## Interface
- APB_ADDR_WIDTH, 32, APB address width; must equal WB_ADDR_WIDTH (elaboration error otherwise)
- APB_DATA_WIDTH, 32, APB data width; must equal WB_DATA_WIDTH
- WB_ADDR_WIDTH, 32, Wishbone address width
- WB_DATA_WIDTH, 32, Wishbone data width
- WB_TIMEOUT_CYCLES, 255, wait-cycle limit; used only with APB2WB_TIMEOUT_EN; must be ≥1
- clk  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- apb_bus  apb_bus_t.slave  -  bridge reads PSEL, PENABLE, PWRITE, PADDR, PWDATA; drives PREADY, PRDATA, PSLVERR
- wb_bus  wb_bus_t.master  -  bridge drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel; reads wb_ack, wb_err, wb_dat_sm

## Operation
- FSM states: IDLE, WB_REQ, APB_RESP.
- IDLE: on PSEL=1 and PENABLE=0 (setup phase), register PADDR, PWDATA, PWRITE -> WB_REQ. Otherwise stay.
- WB_REQ: wb_cyc=wb_stb=1, wb_adr/wb_dat_ms/wb_we from the registered values, wb_sel all ones. On wb_ack=1 or wb_err=1:
  - register rdata = wb_dat_sm on reads, 0 on writes
  - register err = wb_err
  - deassert cyc/stb next cycle, go to APB_RESP
- wb_ack and wb_err both 1: counts as an error; PSLVERR=1, rdata=0.
- APB_RESP: PREADY=1, PRDATA=rdata, PSLVERR=err for exactly one cycle, then IDLE unconditionally.
- PREADY=0 in IDLE and WB_REQ. PRDATA and PSLVERR are 0 whenever PREADY=0.
- wb_ack and wb_err are ignored outside WB_REQ.
- PADDR is passed to wb_adr unchanged (byte address). No address translation and no PSTRB support.
- PSEL dropping during WB_REQ is an APB protocol violation. The bridge still finishes the Wishbone cycle, visits APB_RESP, and returns to IDLE.

## Timing
- Reset values: wb_cyc=0, wb_stb=0, wb_we=0, wb_adr=0, wb_dat_ms=0, wb_sel=0; PREADY=0, PRDATA=0, PSLVERR=0; state IDLE.
- All outputs come from registers; there is no combinational path from the APB inputs to the Wishbone outputs.
- Cycle numbering, T0 = setup cycle:
  - T1: wb_cyc/stb rise, APB access phase starts.
  - Wishbone slave acks in cycle Tk (k≥1): PREADY=1 in Tk+1.
  - Minimum APB transfer: 3 cycles (setup + 2 access).
- Back-to-back: a new setup phase in the cycle after APB_RESP is accepted (IDLE sees it).
- wb_cyc is low for at least one cycle between Wishbone transfers.
- Reset mid-transfer: all outputs return asynchronously to reset values, wb_cyc drops immediately, and the pending APB transfer is abandoned.

## Configuration
- APB2WB_TIMEOUT_EN defined:
  - A counter clears on entry to WB_REQ and increments each WB_REQ cycle without ack/err.
  - When it reaches WB_TIMEOUT_CYCLES: drop cyc/stb next cycle, go to APB_RESP with PSLVERR=1, PRDATA=0.
  - A late wb_ack/wb_err is then ignored.
- Undefined: no counter is built and WB_REQ waits indefinitely.

## Structure
- Shared package apb2wb_pkg: state enum apb2wb_state_e {IDLE, WB_REQ, APB_RESP}.
- Sub-module apb2wb_timeout, instantiated only under APB2WB_TIMEOUT_EN:
  - Inputs clk, rstn_i, clr, en.
  - Output expired.
  - Counter width $clog2(WB_TIMEOUT_CYCLES+1).

## Test plan
- Write 0xCAFEF00D to 0x0000_0010, slave acks in 1st Wishbone cycle: wb_adr=0x10, wb_dat_ms=0xCAFEF00D, wb_we=1 for one cycle; PREADY=1 at T2, PSLVERR=0.
- Read 0x0000_0020, slave returns 0x12345678 after 4 wait cycles: wb_cyc high for 5 cycles; PREADY=1 with PRDATA=0x12345678 one cycle after ack; PREADY=0 earlier.
- Read with wb_err=1 (and with wb_ack=wb_err=1 together): PSLVERR=1, PRDATA=0.
- Two back-to-back APB writes: two Wishbone cycles, wb_cyc low ≥1 cycle between them, each PREADY pulse exactly one cycle.
- With APB2WB_TIMEOUT_EN and WB_TIMEOUT_CYCLES=8, slave never acks: cyc drops after 8 wait cycles, PSLVERR=1; a late ack is ignored; the next transfer completes normally.
- Assert rstn_i=0 during WB_REQ: wb_cyc=0 and PREADY=0 immediately; a fresh transfer after reset works.

Source files
------------

// File: rtl/apb2wb_pkg.sv
// Shared types for the APB-to-Wishbone bridge.
// The optional wait-cycle timeout is built only when APB2WB_TIMEOUT_EN is defined.
package apb2wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_REQ   = 2'd1,
    APB_RESP = 2'd2
  } apb2wb_state_e;

  localparam int unsigned STATE_W = 2;

  // APB setup phase: selected but not yet enabled.
  function automatic logic is_setup(input logic psel, input logic penable);
    return psel & ~penable;
  endfunction

endpackage

// File: rtl/apb2wb_timeout.sv
// Wait-cycle counter for the bridge, instantiated only when APB2WB_TIMEOUT_EN is defined.
// expired pulses in the wait cycle in which the count reaches WB_TIMEOUT_CYCLES.
module apb2wb_timeout #(
  parameter int unsigned WB_TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(WB_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WB_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // This increment is the one that reaches the limit, so the cycle ends now.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/apb2wb.sv
// APB completer that turns each APB transfer into one classic Wishbone single cycle.
// Optional feature: define APB2WB_TIMEOUT_EN to abort Wishbone cycles after WB_TIMEOUT_CYCLES waits.
module apb2wb
  import apb2wb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH    = 32,
  parameter int unsigned APB_DATA_WIDTH    = 32,
  parameter int unsigned WB_ADDR_WIDTH     = 32,
  parameter int unsigned WB_DATA_WIDTH     = 32,
  parameter int unsigned WB_TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rstn_i,
  // APB completer
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [APB_ADDR_WIDTH-1:0]   paddr,
  input  logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic                        pready,
  output logic [APB_DATA_WIDTH-1:0]   prdata,
  output logic                        pslverr,
  // Wishbone master
  output logic                        wb_cyc,
  output logic                        wb_stb,
  output logic                        wb_we,
  output logic [WB_ADDR_WIDTH-1:0]    wb_adr,
  output logic [WB_DATA_WIDTH-1:0]    wb_dat_ms,
  output logic [WB_DATA_WIDTH/8-1:0]  wb_sel,
  input  logic                        wb_ack,
  input  logic                        wb_err,
  input  logic [WB_DATA_WIDTH-1:0]    wb_dat_sm,
  // FSM state for observation
  output logic [STATE_W-1:0]          dbg_state
);

  if (APB_ADDR_WIDTH != WB_ADDR_WIDTH) begin : g_bad_addr_w
    $error("apb2wb: APB_ADDR_WIDTH must equal WB_ADDR_WIDTH");
  end
  if (APB_DATA_WIDTH != WB_DATA_WIDTH) begin : g_bad_data_w
    $error("apb2wb: APB_DATA_WIDTH must equal WB_DATA_WIDTH");
  end
  if (WB_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb2wb: WB_TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake: an APB transfer is accepted in its setup phase (psel=1, penable=0)
  // and held with pready=0 until the Wishbone cycle ends; pready is then high for
  // exactly one cycle with prdata/pslverr valid, and those are 0 whenever pready=0.

  apb2wb_state_e state, next_state;

  logic [WB_ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_WIDTH-1:0] wdata_q;
  logic                     we_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                     err_q;

  logic                      capture;
  logic                      resp_load;
  logic                      resp_err;
  logic [APB_DATA_WIDTH-1:0] resp_data;
  logic                      timeout_hit;

`ifdef APB2WB_TIMEOUT_EN
  apb2wb_timeout #(
    .WB_TIMEOUT_CYCLES(WB_TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn_i (rstn_i),
    .clr    (state != WB_REQ),
    .en     ((state == WB_REQ) && !wb_ack && !wb_err),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state)
      IDLE: begin
        if (is_setup(psel, penable)) begin
          capture    = 1'b1;
          next_state = WB_REQ;
        end
      end
      WB_REQ: begin
        // A real slave response wins over a timeout in the same cycle.
        if (wb_ack || wb_err) begin
          resp_load  = 1'b1;
          resp_err   = wb_err;
          resp_data  = (!we_q && !wb_err) ? wb_dat_sm : '0;
          next_state = APB_RESP;
        end else if (timeout_hit) begin
          resp_load  = 1'b1;
          resp_err   = 1'b1;
          next_state = APB_RESP;
        end
      end
      APB_RESP: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        we_q    <= pwrite;
      end
      if (resp_load) begin
        rdata_q <= resp_data;
        err_q   <= resp_err;
      end
    end
  end

  // Outputs decode registered state only; no APB input reaches Wishbone combinationally.
  assign wb_cyc    = (state == WB_REQ);
  assign wb_stb    = wb_cyc;
  assign wb_we     = wb_cyc & we_q;
  assign wb_adr    = addr_q;
  assign wb_dat_ms = wdata_q;
  assign wb_sel    = {(WB_DATA_WIDTH/8){wb_cyc}};

  assign pready    = (state == APB_RESP);
  assign prdata    = pready ? rdata_q : '0;
  assign pslverr   = pready & err_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_apb2wb.sv
// Directed bench for apb2wb: APB driver task plays the Wishbone slave with a set wait count.
// Define APB2WB_TIMEOUT_EN for both RTL and bench to include the timeout steps.
module tb_apb2wb;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  apb2wb #(
    .WB_TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_ms(wb_dat_ms),
    .wb_sel   (wb_sel),
    .wb_ack   (wb_ack),
    .wb_err   (wb_err),
    .wb_dat_sm(wb_dat_sm),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver: one APB transfer; slave responds in its (waits+1)-th cyc cycle.
  // Returns at the negedge of the pready cycle with psel/penable still high.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic ack, input logic err,
                          input logic [31:0] sm_data,
                          output logic [31:0] rdata, output logic slverr,
                          output int cyc_cnt, output int t_ready);
    int  t;
    bit  done;
    @(negedge clk);
    chk("pre_pready", {31'd0, pready}, 32'd0);
    chk("pre_cyc", {31'd0, wb_cyc}, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    cyc_cnt = 0; t_ready = -1; rdata = 'x; slverr = 1'bx; done = 1'b0; t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
      penable = 1'b1;
      if (wb_cyc) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          chk("wb_adr", wb_adr, addr);
          chk("wb_dat_ms", wb_dat_ms, wdata);
          chk("wb_we", {31'd0, wb_we}, {31'd0, wr});
          chk("wb_stb", {31'd0, wb_stb}, 32'd1);
          chk("wb_sel", {28'd0, wb_sel}, 32'hF);
        end
        if (cyc_cnt == waits + 1) begin
          wb_ack = ack; wb_err = err; wb_dat_sm = sm_data;
        end else begin
          wb_ack = 1'b0; wb_err = 1'b0; wb_dat_sm = 32'hA5A5_A5A5;
        end
        if (pready) chk("pready_during_cyc", {31'd0, pready}, 32'd0);
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0;
      end
      if (pready) begin
        done = 1'b1;
        t_ready = t;
        rdata = prdata;
        slverr = pslverr;
      end
    end
    chk("pready_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic apb_idle();
    @(negedge clk);
    chk("pready_one_cycle", {31'd0, pready}, 32'd0);
    chk("idle_cyc", {31'd0, wb_cyc}, 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  // scoreboard: compare a response against the oldest expected entry
  task automatic score(input string tag, input logic [31:0] rdata, input logic slverr);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_prdata"}, rdata, e[31:0]);
      chk({tag, "_pslverr"}, {31'd0, slverr}, {31'd0, e[32]});
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        se;
    int          cc, tr;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_sm = '0;
    rstn_i = 1'b0;
    #1;
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_dat_ms", wb_dat_ms, 32'd0);
    chk("rst_sel", {28'd0, wb_sel}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;

    // write, zero-wait ack: cyc one cycle, pready at T2; slave data ignored on writes
    exp_q.push_back({1'b0, 32'h0});
    apb_xfer(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h1111_2222, rd, se, cc, tr);
    chk("wr_cyc_len", cc, 1);
    chk("wr_t_ready", tr, 2);
    score("wr", rd, se);
    apb_idle();

    // read with 4 wait cycles
    exp_q.push_back({1'b0, 32'h1234_5678});
    apb_xfer(1'b0, 32'h0000_0020, 32'h0, 4, 1'b1, 1'b0, 32'h1234_5678, rd, se, cc, tr);
    chk("rd_cyc_len", cc, 5);
    chk("rd_t_ready", tr, 6);
    score("rd", rd, se);
    apb_idle();

    // read terminated by wb_err
    exp_q.push_back({1'b1, 32'h0});
    apb_xfer(1'b0, 32'h0000_0030, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, rd, se, cc, tr);
    chk("err_cyc_len", cc, 2);
    score("err", rd, se);
    apb_idle();

    // read with ack and err together
    exp_q.push_back({1'b1, 32'h0});
    apb_xfer(1'b0, 32'h0000_0034, 32'h0, 0, 1'b1, 1'b1, 32'hBEEF_CAFE, rd, se, cc, tr);
    chk("ackerr_t_ready", tr, 2);
    score("ackerr", rd, se);
    apb_idle();

    // back-to-back writes: second setup in the cycle after APB_RESP
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0});
    apb_xfer(1'b1, 32'h0000_0100, 32'h0102_0304, 0, 1'b1, 1'b0, 32'h0, rd, se, cc, tr);
    chk("b2b1_cyc_len", cc, 1);
    score("b2b1", rd, se);
    apb_xfer(1'b1, 32'h0000_0104, 32'h0506_0708, 1, 1'b1, 1'b0, 32'h0, rd, se, cc, tr);
    chk("b2b2_cyc_len", cc, 2);
    chk("b2b2_t_ready", tr, 3);
    score("b2b2", rd, se);
    apb_idle();

`ifdef APB2WB_TIMEOUT_EN
    // slave never responds: 8 wait cycles then error
    exp_q.push_back({1'b1, 32'h0});
    apb_xfer(1'b0, 32'h0000_0200, 32'h0, 100, 1'b0, 1'b0, 32'h0, rd, se, cc, tr);
    chk("to_cyc_len", cc, 8);
    chk("to_t_ready", tr, 9);
    score("to", rd, se);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    wb_ack = 1'b1; wb_dat_sm = 32'h7777_7777;
    chk("late_ack_pready", {31'd0, pready}, 32'd0);
    @(negedge clk);
    wb_ack = 1'b0;
    chk("late_ack_pready2", {31'd0, pready}, 32'd0);
    chk("late_ack_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("late_ack_state", {30'd0, dbg_state}, 32'd0);
    exp_q.push_back({1'b0, 32'hFEED_0001});
    apb_xfer(1'b0, 32'h0000_0204, 32'h0, 2, 1'b1, 1'b0, 32'hFEED_0001, rd, se, cc, tr);
    chk("after_to_cyc_len", cc, 3);
    score("after_to", rd, se);
    apb_idle();
`endif

    // reset during WB_REQ
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0040; pwdata = 32'h5555_AAAA;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_cyc", {31'd0, wb_cyc}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_pready", {31'd0, pready}, 32'd0);
    chk("mid_rst_adr", wb_adr, 32'd0);
    chk("mid_rst_sel", {28'd0, wb_sel}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    apb_xfer(1'b0, 32'h0000_0044, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_F00D, rd, se, cc, tr);
    chk("post_rst_t_ready", tr, 3);
    score("post_rst", rd, se);
    apb_idle();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
